call_ret_ctrl: RTL and testbench

CALL_RET_CTRL -- requirements
Module: call_ret_ctrl

---
 rtl/call_ret_ctrl.sv | 171 +++++++++++++++++
 tb/tb_call_ret_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/call_ret_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : call_ret_ctrl
// Purpose  : CALL/RET sequencer. Sequences a push plus jump for CALL and a
//            pop plus PC/flag restore for RET, and tracks stack occupancy.
// Options  : CALL_RET_GUARD_EN - when defined, a CALL at full depth or a RET
//            at zero depth is refused and raises a sticky overflow/underflow.
//            When undefined, both always execute and depth saturates.
// Revision : 1.0 - initial release
// ============================================================================
module call_ret_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       call_req,
    input  logic       ret_req,
    input  logic [8:0] cur_pc,
    input  logic [3:0] cur_flags,
    input  logic [8:0] target_pc,
    input  logic [8:0] tos_pc,
    input  logic [3:0] tos_flags,
    output logic       push_en,
    output logic       pop_en,
    output logic [8:0] push_pc,
    output logic [3:0] push_flags,
    output logic       pc_load,
    output logic [8:0] next_pc,
    output logic       flags_load,
    output logic [3:0] restore_flags,
    output logic       busy,
    output logic [2:0] depth,
    output logic       overflow,
    output logic       underflow
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_CALL_PUSH = 3'd1;
    localparam logic [2:0] c_CALL_JUMP = 3'd2;
    localparam logic [2:0] c_RET_POP   = 3'd3;
    localparam logic [2:0] c_RET_JUMP  = 3'd4;
    localparam logic [2:0] c_MAX_DEPTH = 3'd5;

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [8:0] r_target;
    logic [8:0] r_push_pc;
    logic [3:0] r_push_flags;
    logic [8:0] r_next_pc;
    logic [3:0] r_restore_flags;
    logic [2:0] r_depth;
    logic       w_call_blocked;
    logic       w_ret_blocked;
    logic       w_push_en;
    logic       w_pop_en;
    logic       w_pc_load;
    logic       w_flags_load;

`ifdef CALL_RET_GUARD_EN
    logic r_overflow;
    logic r_underflow;

    assign w_call_blocked = (r_depth == c_MAX_DEPTH);
    assign w_ret_blocked  = (r_depth == 3'd0);

    // Sticky error flags, raised during the single busy cycle of a refused op
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (r_state == c_CALL_PUSH && w_call_blocked) r_overflow  <= 1'b1;
            if (r_state == c_RET_POP   && w_ret_blocked)  r_underflow <= 1'b1;
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    assign w_call_blocked = 1'b0;
    assign w_ret_blocked  = 1'b0;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state and strobe decode; CALL has priority over RET in IDLE
    always_comb begin
        w_next_state = r_state;
        w_push_en    = 1'b0;
        w_pop_en     = 1'b0;
        w_pc_load    = 1'b0;
        w_flags_load = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (call_req)     w_next_state = c_CALL_PUSH;
                else if (ret_req) w_next_state = c_RET_POP;
            end
            c_CALL_PUSH: begin
                w_push_en    = ~w_call_blocked;
                w_next_state = w_call_blocked ? c_IDLE : c_CALL_JUMP;
            end
            c_CALL_JUMP: begin
                w_pc_load    = 1'b1;
                w_next_state = c_IDLE;
            end
            c_RET_POP: begin
                w_pop_en     = ~w_ret_blocked;
                w_next_state = w_ret_blocked ? c_IDLE : c_RET_JUMP;
            end
            c_RET_JUMP: begin
                w_pc_load    = 1'b1;
                w_flags_load = 1'b1;
                w_next_state = c_IDLE;
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // Datapath: capture CALL operands, latch TOS before the pop lands, track depth
    always_ff @(posedge clk) begin
        if (rst) begin
            r_target        <= 9'd0;
            r_push_pc       <= 9'd0;
            r_push_flags    <= 4'd0;
            r_next_pc       <= 9'd0;
            r_restore_flags <= 4'd0;
            r_depth         <= 3'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (call_req) begin
                        r_push_pc    <= cur_pc;
                        r_push_flags <= cur_flags;
                        r_target     <= target_pc;
                    end
                end
                c_CALL_PUSH: begin
                    if (!w_call_blocked) begin
                        r_next_pc <= r_target;
                        if (r_depth != c_MAX_DEPTH) r_depth <= r_depth + 3'd1;
                    end
                end
                c_RET_POP: begin
                    if (!w_ret_blocked) begin
                        r_next_pc       <= tos_pc;
                        r_restore_flags <= tos_flags;
                        if (r_depth != 3'd0) r_depth <= r_depth - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign push_en       = w_push_en;
    assign pop_en        = w_pop_en;
    assign pc_load       = w_pc_load;
    assign flags_load    = w_flags_load;
    assign push_pc       = r_push_pc;
    assign push_flags    = r_push_flags;
    assign next_pc       = r_next_pc;
    assign restore_flags = r_restore_flags;
    assign depth         = r_depth;
    assign busy          = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_call_ret_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_call_ret_ctrl
// Purpose  : Self-checking bench for call_ret_ctrl. A transaction-level model
//            (occupancy count plus a list of pushed return addresses) predicts
//            every strobe, data output and error flag. A small call stack is
//            emulated around the DUT so that RET has real TOS data.
// Options  : CALL_RET_GUARD_EN changes the expected behaviour at depth limits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_call_ret_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       call_req, ret_req;
    logic [8:0] cur_pc, target_pc, tos_pc;
    logic [3:0] cur_flags, tos_flags;
    logic       push_en, pop_en, pc_load, flags_load, busy, overflow, underflow;
    logic [8:0] push_pc, next_pc;
    logic [3:0] push_flags, restore_flags;
    logic [2:0] depth;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_depth;
    bit          m_ovf, m_unf;
    logic [12:0] m_stack[$];

    // Emulated call stack (driven by the DUT strobes)
    logic [12:0] env_q[$];
    logic [12:0] env_top;

    call_ret_ctrl dut (
        .clk(clk), .rst(rst), .call_req(call_req), .ret_req(ret_req),
        .cur_pc(cur_pc), .cur_flags(cur_flags), .target_pc(target_pc),
        .tos_pc(tos_pc), .tos_flags(tos_flags),
        .push_en(push_en), .pop_en(pop_en), .push_pc(push_pc), .push_flags(push_flags),
        .pc_load(pc_load), .next_pc(next_pc), .flags_load(flags_load),
        .restore_flags(restore_flags), .busy(busy), .depth(depth),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Stack emulation: push stores PC+1, holds 5 entries, empty reads as 0
    always @(posedge clk) begin
        if (rst) begin
            env_q.delete();
        end else if (push_en) begin
            env_q.push_back({push_flags, 9'(push_pc + 9'd1)});
            if (env_q.size() > 5) void'(env_q.pop_front());
        end else if (pop_en && env_q.size() > 0) begin
            void'(env_q.pop_back());
        end
        env_top = (env_q.size() > 0) ? env_q[$] : 13'd0;
        tos_pc    <= env_top[8:0];
        tos_flags <= env_top[12:9];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_depth = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_stack.delete();
    endtask

    // One request and its full expected response
    task automatic do_op(input bit c, input bit r, input logic [8:0] pc,
                         input logic [3:0] fl, input logic [8:0] tgt);
        bit          is_call, is_ret, blocked;
        logic [12:0] top;
        is_call = c;
        is_ret  = !c && r;
        @(negedge clk);
        call_req  = c;
        ret_req   = r;
        cur_pc    = pc;
        cur_flags = fl;
        target_pc = tgt;
        @(negedge clk);
        call_req  = 1'b0;
        ret_req   = 1'b0;
        cur_pc    = 9'($urandom);
        cur_flags = 4'($urandom);
        target_pc = 9'($urandom);
        blocked = 1'b0;
`ifdef CALL_RET_GUARD_EN
        blocked = (is_call && m_depth == 5) || (is_ret && m_depth == 0);
`endif
        top = (m_stack.size() > 0) ? m_stack[$] : 13'd0;
        chk("busy_n1",    busy,    1'b1);
        chk("push_en_n1", push_en, is_call && !blocked);
        chk("pop_en_n1",  pop_en,  is_ret && !blocked);
        chk("pc_load_n1", pc_load, 1'b0);
        if (is_call && !blocked) begin
            chk("push_pc",    push_pc,    pc);
            chk("push_flags", push_flags, fl);
        end
        @(negedge clk);
        if (blocked) begin
            if (is_call) m_ovf = 1'b1;
            else         m_unf = 1'b1;
            chk("busy_blk",    busy,       1'b0);
            chk("pc_load_blk", pc_load,    1'b0);
            chk("flags_blk",   flags_load, 1'b0);
        end else begin
            chk("pc_load_n2",   pc_load,    1'b1);
            chk("flags_ld_n2",  flags_load, is_ret);
            chk("push_en_n2",   push_en,    1'b0);
            chk("pop_en_n2",    pop_en,     1'b0);
            chk("next_pc",      next_pc,    is_call ? tgt : top[8:0]);
            if (is_ret) chk("restore_flags", restore_flags, top[12:9]);
            if (is_call) begin
                m_stack.push_back({fl, 9'(pc + 9'd1)});
                if (m_stack.size() > 5) void'(m_stack.pop_front());
                m_depth = (m_depth < 5) ? m_depth + 1 : 5;
            end else begin
                if (m_stack.size() > 0) void'(m_stack.pop_back());
                m_depth = (m_depth > 0) ? m_depth - 1 : 0;
            end
        end
        chk("depth",     depth,     m_depth[2:0]);
        chk("overflow",  overflow,  m_ovf);
        chk("underflow", underflow, m_unf);
        if (!blocked) begin
            @(negedge clk);
            chk("busy_n3",    busy,    1'b0);
            chk("pc_load_n3", pc_load, 1'b0);
        end
    endtask

    // Reset landing in CALL_PUSH must cancel the pending jump
    task automatic reset_mid_call(input logic [8:0] pc, input logic [8:0] tgt);
        @(negedge clk);
        call_req  = 1'b1;
        cur_pc    = pc;
        cur_flags = 4'hA;
        target_pc = tgt;
        @(negedge clk);
        call_req = 1'b0;
        chk("rst_mid_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("rst_mid_pc_load", pc_load, 1'b0);
        chk("rst_mid_busy0",   busy,    1'b0);
        chk("rst_mid_depth",   depth,   3'd0);
        chk("rst_mid_next_pc", next_pc, 9'd0);
        chk("rst_mid_push_pc", push_pc, 9'd0);
        @(negedge clk);
        chk("rst_mid_pc_load2", pc_load, 1'b0);
        chk("rst_mid_push_en2", push_en, 1'b0);
    endtask

    initial begin
        int pushes;
        rst = 1'b1;
        call_req = 1'b0; ret_req = 1'b0;
        cur_pc = 9'd0; cur_flags = 4'd0; target_pc = 9'd0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_busy",      busy,          1'b0);
        chk("rst_push_en",   push_en,       1'b0);
        chk("rst_pop_en",    pop_en,        1'b0);
        chk("rst_pc_load",   pc_load,       1'b0);
        chk("rst_flags_ld",  flags_load,    1'b0);
        chk("rst_depth",     depth,         3'd0);
        chk("rst_overflow",  overflow,      1'b0);
        chk("rst_underflow", underflow,     1'b0);
        chk("rst_next_pc",   next_pc,       9'd0);
        chk("rst_restore",   restore_flags, 4'd0);
        chk("rst_push_pc",   push_pc,       9'd0);
        chk("rst_push_fl",   push_flags,    4'd0);
        rst = 1'b0;

        // Directed CALL then RET
        do_op(1'b1, 1'b0, 9'h010, 4'h5, 9'h100);
        do_op(1'b0, 1'b1, 9'h000, 4'h0, 9'h000);
        chk("ret_next_pc_0x011", next_pc, 9'h011);
        chk("ret_flags_0x5",     restore_flags, 4'h5);

        // Simultaneous requests: CALL wins
        do_op(1'b1, 1'b1, 9'h0AB, 4'h3, 9'h1C0);
        do_op(1'b0, 1'b1, 9'h000, 4'h0, 9'h000);

        // Six CALLs from empty: count push strobes in the model's terms
        pushes = 0;
        for (int i = 0; i < 6; i++) begin
            if (m_depth < 5) pushes++;
`ifndef CALL_RET_GUARD_EN
            else pushes++;
`endif
            do_op(1'b1, 1'b0, 9'(9'h020 + i), 4'(i), 9'(9'h140 + i));
        end
        chk("six_calls_depth", depth, 3'd5);
`ifdef CALL_RET_GUARD_EN
        chk("six_calls_pushes", 16'(pushes), 16'd5);
        chk("six_calls_ovf",    overflow,    1'b1);
`else
        chk("six_calls_pushes", 16'(pushes), 16'd6);
        chk("six_calls_ovf",    overflow,    1'b0);
`endif

        // Drain past empty: final RET exercises the depth-0 boundary
        for (int i = 0; i < 6; i++) do_op(1'b0, 1'b1, 9'h000, 4'h0, 9'h000);
        chk("drain_depth", depth, 3'd0);

        // Reset mid-sequence
        reset_mid_call(9'h055, 9'h1AA);

        // Randomized mix
        for (int i = 0; i < 60; i++) begin
            int sel;
            sel = int'($urandom_range(0, 19));
            if (sel == 0)
                reset_mid_call(9'($urandom), 9'($urandom));
            else if (sel < 10)
                do_op(1'b1, 1'b0, 9'($urandom), 4'($urandom), 9'($urandom));
            else if (sel < 18)
                do_op(1'b0, 1'b1, 9'($urandom), 4'($urandom), 9'($urandom));
            else
                do_op(1'b1, 1'b1, 9'($urandom), 4'($urandom), 9'($urandom));
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
